// File: rtl/pin_driver_if.sv
// Pin-driver bundle: tick enable, request/data, readback and fault control in;
// registered pin value, output enable and status out.
interface pin_driver_if;
   logic ena;
   logic req;
   logic din;
   logic pin_in;
   logic clr_fault;
   logic pin_out;
   logic pin_oe;
   logic busy;
   logic fault;

   modport master (
      output ena, req, din, pin_in, clr_fault,
      input  pin_out, pin_oe, busy, fault
   );

   modport slave (
      input  ena, req, din, pin_in, clr_fault,
      output pin_out, pin_oe, busy, fault
   );
endinterface

// File: rtl/pin_driver.sv
// Drives one bidirectional bus pin with hold-after-release, a hi-Z guard before the
// next drive, and readback-based contention detection that releases the pin on a fault.
module pin_driver #(
   parameter int unsigned HOLD_TICKS  = 2,
   parameter int unsigned GUARD_TICKS = 2,
   parameter int unsigned CONT_TICKS  = 3,
   parameter int unsigned CNT_W       = 4
) (
   input logic         clk,
   input logic         reset_n,
   pin_driver_if.slave bus
);

   typedef enum logic [1:0] {HIZ, DRIVE, HOLD, GUARD} state_t;

   localparam logic [CNT_W-1:0] HOLD_LOAD  = (HOLD_TICKS > 0) ? CNT_W'(HOLD_TICKS - 1) : '0;
   localparam logic [CNT_W-1:0] GUARD_LOAD = (GUARD_TICKS > 0) ? CNT_W'(GUARD_TICKS - 1) : '0;
   localparam logic [CNT_W-1:0] CONT_LAST  = CNT_W'(CONT_TICKS - 1);
   localparam state_t           REL_STATE  = (GUARD_TICKS > 0) ? GUARD : HIZ;
   localparam logic             REL_BUSY   = (GUARD_TICKS > 0) ? 1'b1 : 1'b0;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] mcnt;
   logic             pin_out_q;
   logic             oe_q;
   logic             busy_q;
   logic             fault_q;

   logic rehold;
   logic load;
   logic out_change;
   logic mismatch;
   logic trip;

   // A pin_out update (or re-entry into DRIVE) restarts the mismatch window so that
   // the readback's propagation lag is never mistaken for contention.
   assign rehold     = (state == HOLD) && bus.req;
   assign load       = bus.req && ((state == DRIVE) || (state == HOLD));
   assign out_change = load && (bus.din != pin_out_q);
   assign mismatch   = oe_q && (bus.pin_in != pin_out_q);
   assign trip       = mismatch && (mcnt == CONT_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= HIZ;
         cnt       <= '0;
         mcnt      <= '0;
         pin_out_q <= 1'b1;
         oe_q      <= 1'b0;
         busy_q    <= 1'b0;
         fault_q   <= 1'b0;
      end else if (bus.ena) begin
         if (bus.clr_fault) fault_q <= 1'b0;

         if (oe_q) begin
            if (rehold || out_change || !mismatch) mcnt <= '0;
            else                                   mcnt <= mcnt + CNT_W'(1);
         end

         unique case (state)
            HIZ: begin
               if (bus.req && !fault_q) begin
                  state     <= DRIVE;
                  pin_out_q <= bus.din;
                  oe_q      <= 1'b1;
                  busy_q    <= 1'b1;
                  mcnt      <= '0;
               end
            end
            DRIVE: begin
               if (bus.req) begin
                  pin_out_q <= bus.din;
               end else if (HOLD_TICKS > 0) begin
                  state <= HOLD;
                  cnt   <= HOLD_LOAD;
               end else begin
                  state  <= REL_STATE;
                  cnt    <= GUARD_LOAD;
                  oe_q   <= 1'b0;
                  busy_q <= REL_BUSY;
               end
            end
            HOLD: begin
               if (bus.req) begin
                  state     <= DRIVE;
                  pin_out_q <= bus.din;
               end else if (cnt == '0) begin
                  state  <= REL_STATE;
                  cnt    <= GUARD_LOAD;
                  oe_q   <= 1'b0;
                  busy_q <= REL_BUSY;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            GUARD: begin
               if (cnt == '0) begin
                  state  <= HIZ;
                  busy_q <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= HIZ;
         endcase

         // Contention overrides any request/hold transition and a same-tick clear.
         if (trip) begin
            fault_q   <= 1'b1;
            state     <= REL_STATE;
            cnt       <= GUARD_LOAD;
            oe_q      <= 1'b0;
            busy_q    <= REL_BUSY;
            pin_out_q <= pin_out_q;
         end
      end
   end

   assign bus.pin_out = pin_out_q;
   assign bus.pin_oe  = oe_q;
   assign bus.busy    = busy_q;
   assign bus.fault   = fault_q;

endmodule
